// File: rtl/rr_mux_arb_pkg.sv
// Shared constants and helpers for the round-robin / fixed-priority output mux.
package rr_mux_pkg;

  localparam logic MODE_RR    = 1'b0;
  localparam logic MODE_FIXED = 1'b1;

  // Index width that never collapses to zero bits.
  function automatic int unsigned clog2_safe(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_mux_arb_if.sv
// Producer-side and consumer-side handshake bundle for rr_mux_arb.
interface rr_mux_arb_if
  import rr_mux_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned SELW = clog2_safe(N);

  logic                 en;
  logic                 mode;
  logic [N-1:0]         in_valid;
  logic [N*WIDTH-1:0]   in_data;
  logic [N-1:0]         in_ready;
  logic                 out_valid;
  logic [WIDTH-1:0]     out_data;
  logic [SELW-1:0]      out_sel;
  logic                 out_ready;

  // Arbiter side.
  modport slave (
    input  en, mode, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );

  // Environment side: producers plus consumer.
  modport master (
    output en, mode, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );
endinterface

// File: rtl/rr_mux_arb_grant.sv
// Combinational round-robin grant: lowest request at or above the pointer, wrapping to 0.
module rr_grant
  import rr_mux_pkg::*;
#(
  parameter int unsigned N = 4,
  localparam int unsigned SELW = clog2_safe(N)
) (
  input  logic [N-1:0]    i_req,
  input  logic [SELW-1:0] i_ptr,
  output logic [N-1:0]    o_gnt,
  output logic [SELW-1:0] o_idx,
  output logic            o_any
);

  logic [N-1:0]   w_mask;
  logic [2*N-1:0] w_dbl;
  logic [SELW:0]  w_pos;
  logic           w_found;

  // Keep only requests at or above the pointer in the low copy; the high copy covers the wrap.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < int'(N); i++) begin
      w_mask[i] = (i >= int'(i_ptr));
    end
  end

  assign w_dbl = {i_req, i_req & w_mask};

  // Lowest set bit of the double-width vector.
  always_comb begin
    w_pos   = '0;
    w_found = 1'b0;
    for (int i = 0; i < int'(2 * N); i++) begin
      if (!w_found && w_dbl[i]) begin
        w_pos   = (SELW + 1)'(i);
        w_found = 1'b1;
      end
    end
  end

  assign o_any = |i_req;
  assign o_idx = (w_pos >= (SELW + 1)'(N)) ? SELW'(w_pos - (SELW + 1)'(N)) : SELW'(w_pos);
  assign o_gnt = o_any ? (N'(1) << o_idx) : '0;

endmodule

// File: rtl/rr_mux_arb.sv
// N-channel registered mux; each output word is won by round-robin or fixed-priority arbitration.
module rr_mux_arb
  import rr_mux_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned SELW = clog2_safe(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  rr_mux_arb_if.slave  bus
);

  logic [SELW-1:0]  r_ptr;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [SELW-1:0]  r_out_sel;

  logic [SELW-1:0]  w_ptr_eff;
  logic [N-1:0]     w_gnt;
  logic [SELW-1:0]  w_idx;
  logic             w_any;
  logic             w_load_ok;
  logic             w_xfer;
  logic [WIDTH-1:0] w_data;

  // Fixed priority is round-robin searched from channel 0; the stored pointer is left untouched.
  assign w_ptr_eff = (bus.mode == MODE_FIXED) ? '0 : r_ptr;

  rr_grant #(
    .N (N)
  ) u_grant (
    .i_req (bus.in_valid),
    .i_ptr (w_ptr_eff),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  // Output slot is free when empty or being drained this cycle.
  assign w_load_ok = bus.en & (~r_out_valid | bus.out_ready);

  // rst_n gating keeps producers from seeing an accept while reset is held.
  assign w_xfer      = rst_n & w_load_ok & w_any;
  assign bus.in_ready = w_xfer ? w_gnt : '0;

  assign w_data = bus.in_data[w_idx*WIDTH +: WIDTH];

  // Output register, pointer advance and drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= '0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_data;
      r_out_sel   <= w_idx;
      if (bus.mode == MODE_RR) begin
        r_ptr <= (w_idx == SELW'(N - 1)) ? '0 : w_idx + 1'b1;
      end
    end else if (r_out_valid && bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_sel   = r_out_sel;

endmodule

// File: tb/tb_rr_mux_arb.sv
// Directed bench for rr_mux_arb with a scoreboard queue checked by a separate output monitor.
module tb_rr_mux_arb;

  localparam int unsigned N     = 4;
  localparam int unsigned WIDTH = 8;

  logic clk;
  logic rst_n;

  rr_mux_arb_if #(.N(N), .WIDTH(WIDTH)) bus ();

  rr_mux_arb #(
    .N     (N),
    .WIDTH (WIDTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;
  logic [9:0] sb_q[$];   // {sel, data}
  logic [9:0] mon_exp;
  logic [9:0] dropped;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Hand-supplied expected in_ready; an accepted word is queued for the monitor.
  task automatic step(input logic e, input logic m, input logic [3:0] v, input logic r,
                      input logic [3:0] exp_rdy, input string name);
    logic [1:0] sel;
    bus.en        = e;
    bus.mode      = m;
    bus.in_valid  = v;
    bus.out_ready = r;
    #1;
    chk({name, "_in_ready"}, 32'(bus.in_ready), 32'(exp_rdy));
    if (exp_rdy != 4'b0000) begin
      sel = 2'd0;
      for (int i = 0; i < 4; i++) if (exp_rdy[i]) sel = 2'(i);
      sb_q.push_back({sel, 8'(sel * 8'h11)});
    end
    @(posedge clk);
    #1;
  endtask

  // Consumer monitor: a word is taken on the edge following a negedge that sees valid&ready.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        if (sb_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_output: got sel %0d data %0h expected none",
                   bus.out_sel, bus.out_data);
        end else begin
          mon_exp = sb_q.pop_front();
          chk("out_sel", 32'(bus.out_sel), 32'(mon_exp[9:8]));
          chk("out_data", 32'(bus.out_data), 32'(mon_exp[7:0]));
        end
      end
    end
  end

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n         = 1'b0;
    bus.en        = 1'b1;
    bus.mode      = 1'b0;
    bus.in_valid  = 4'b1111;
    bus.in_data   = {8'h33, 8'h22, 8'h11, 8'h00};
    bus.out_ready = 1'b1;

    // Reset state with every channel requesting.
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'h0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_out_data", 32'(bus.out_data), 32'h0);
    chk("rst_out_sel", 32'(bus.out_sel), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Round-robin fairness: 0,1,2,3,0.
    step(1, 0, 4'b1111, 1, 4'b0001, "rr0");
    chk("rr_lat_valid", 32'(bus.out_valid), 32'h1);
    step(1, 0, 4'b1111, 1, 4'b0010, "rr1");
    step(1, 0, 4'b1111, 1, 4'b0100, "rr2");
    step(1, 0, 4'b1111, 1, 4'b1000, "rr3");
    step(1, 0, 4'b1111, 1, 4'b0001, "rr4");

    // Fixed priority: ch1 wins over ch2 until it drops.
    step(1, 1, 4'b0110, 1, 4'b0010, "fx0");
    step(1, 1, 4'b0110, 1, 4'b0010, "fx1");
    step(1, 1, 4'b0110, 1, 4'b0010, "fx2");
    step(1, 1, 4'b0100, 1, 4'b0100, "fx3");

    // Backpressure: stored pointer is still 1 after fixed mode.
    step(1, 0, 4'b1111, 1, 4'b0010, "bp_load");
    for (int k = 0; k < 5; k++) begin
      step(1, 0, 4'b1111, 0, 4'b0000, "bp_stall");
      chk("bp_valid", 32'(bus.out_valid), 32'h1);
      chk("bp_data", 32'(bus.out_data), 32'h11);
      chk("bp_sel", 32'(bus.out_sel), 32'h1);
    end
    step(1, 0, 4'b1111, 1, 4'b0100, "bp_resume");

    // Enable low: drain only, pointer stays at 3.
    step(0, 0, 4'b1111, 1, 4'b0000, "en_off0");
    chk("en_drained", 32'(bus.out_valid), 32'h0);
    chk("en_hold_data", 32'(bus.out_data), 32'h22);
    step(0, 0, 4'b1111, 1, 4'b0000, "en_off1");
    chk("en_idle_valid", 32'(bus.out_valid), 32'h0);
    step(1, 0, 4'b1111, 1, 4'b1000, "en_on0");
    step(1, 0, 4'b1111, 1, 4'b0001, "en_on1");

    // Async reset between edges discards the held word.
    step(1, 0, 4'b1111, 1, 4'b0010, "ar_load");
    bus.out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(bus.out_valid), 32'h0);
    chk("ar_data", 32'(bus.out_data), 32'h0);
    chk("ar_in_ready", 32'(bus.in_ready), 32'h0);
    dropped = sb_q.pop_back();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1, 0, 4'b1111, 1, 4'b0001, "ar_ptr0");

    // Idle with no requests, then confirm every queued word was seen.
    step(1, 0, 4'b0000, 1, 4'b0000, "idle0");
    step(1, 0, 4'b0000, 1, 4'b0000, "idle1");
    chk("sb_empty", 32'(sb_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
